// File: rtl/uart_bus_master.sv
// uart_bus_master: turns a UART byte stream into single 32-bit peripheral bus
// reads/writes and answers through the UART transmitter byte interface.
//   Packets (MSB first): write = 57 a3 a2 a1 a0 d3 d2 d1 d0, read = 52 a3 a2 a1 a0.
//   Replies: ACK_BYTE after a write, 4 data bytes after a read, NAK_BYTE for an
//   unknown command byte.
// Ports:
//   clk, reset (sync, active-high)
//   rx_data/rx_valid (receiver byte strobe)
//   tx_data/tx_start/tx_busy (transmitter handshake)
//   rd/wr/addr/wdata/rdata (bus initiator)
//   busy (engine not idle)
module uart_bus_master #(
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, SEND, SEND_WAIT} state_t;

  state_t          state, state_nxt;
  logic            op_wr;
  logic [1:0]      byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [31:0]     tx_shift;   // response bytes, MSB goes out first
  logic [2:0]      tx_left;    // bytes still to transmit, including current
  logic            start_q;    // first SEND_WAIT cycle: tx_busy not yet valid
  logic            tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  // Current byte sits in the top of the shift register and only moves once the
  // transmitter has finished it, so tx_data is stable for the whole transfer.
  assign tx_data = tx_shift[31:24];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr        = 1'b0;
    tx_start  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) state_nxt = ADDR;
          else                                      state_nxt = SEND;
        end
      end
      ADDR: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = op_wr ? DATA : BUS;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = BUS;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      BUS: begin
        rd        = ~op_wr;
        wr        = op_wr;
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        if (!start_q && !tx_busy) state_nxt = (tx_left == 3'd1) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_wr    <= 1'b0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      addr     <= '0;
      wdata    <= '0;
      tx_shift <= '0;
      tx_left  <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= tx_start;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            op_wr    <= (rx_data == 8'h57);
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            if (rx_data != 8'h57 && rx_data != 8'h52) begin
              tx_shift <= {NAK_BYTE, 24'h0};
              tx_left  <= 3'd1;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr     <= {addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 ready for DATA
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            wdata    <= {wdata[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
        end
        BUS: begin
          if (op_wr) begin
            tx_shift <= {ACK_BYTE, 24'h0};
            tx_left  <= 3'd1;
          end else begin
            tx_shift <= rdata;
            tx_left  <= 3'd4;
          end
        end
        SEND_WAIT: begin
          if (!start_q && !tx_busy) begin
            tx_shift <= {tx_shift[23:0], 8'h00};
            tx_left  <= tx_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int hold     = 3;
  logic [7:0] txq[$];

  uart_bus_master #(.TIMEOUT(16), .ACK_BYTE(8'h4B), .NAK_BYTE(8'h3F)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    rd_cnt = 0;
    txq.delete();
  endtask

  // Bus monitor: count strobes, never both at once.
  initial begin
    forever begin
      @(negedge clk);
      if (rd || wr) check("rd_wr_excl", {30'h0, rd, wr} & {30'h0, rd & wr, rd & wr}, 32'h0);
      if (rd) rd_cnt++;
      if (wr) wr_cnt++;
    end
  end

  // Transmitter model: busy rises the cycle after tx_start for `hold` cycles,
  // tx_data must stay put for the whole transfer.
  initial begin
    logic [7:0] b;
    int h;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        check("tx_start_while_busy", {31'h0, tx_busy}, 32'h0);
        b = tx_data;
        h = hold;
        txq.push_back(b);
        @(posedge clk); #1;
        tx_busy = 1'b1;
        for (int i = 0; i < h; i++) begin
          @(negedge clk);
          check("tx_data_stable", {24'h0, tx_data}, {24'h0, b});
          @(posedge clk);
        end
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    int idle_edge;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rdata    = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd",       {31'h0, rd},       32'h0);
    check("rst_wr",       {31'h0, wr},       32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_addr",     addr,              32'h0);
    check("rst_wdata",    wdata,             32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    reset = 1'b0;

    // Write packet
    clear_counts();
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA5);
    @(negedge clk);   // cycle after the edge that saw the last byte
    check("wr_latency", {31'h0, wr}, 32'h1);
    check("wr_addr",    addr,        32'h4000000C);
    check("wr_wdata",   wdata,       32'h000000A5);
    wait_idle(100);
    check("wr_count",   wr_cnt,      1);
    check("wr_rd_count", rd_cnt,     0);
    check("wr_tx_count", txq.size(), 1);
    if (txq.size() >= 1) check("wr_ack", {24'h0, txq[0]}, 32'h4B);
    check("wr_addr_kept", addr, 32'h4000000C);

    // Read packet
    clear_counts();
    rdata = 32'h12345678;
    send_byte(8'h52);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    @(negedge clk);
    check("rd_latency", {31'h0, rd}, 32'h1);
    check("rd_addr",    addr,        32'h40000010);
    wait_idle(200);
    check("rd_count",    rd_cnt,     1);
    check("rd_wr_count", wr_cnt,     0);
    check("rd_tx_count", txq.size(), 4);
    if (txq.size() == 4) begin
      check("rd_b0", {24'h0, txq[0]}, 32'h12);
      check("rd_b1", {24'h0, txq[1]}, 32'h34);
      check("rd_b2", {24'h0, txq[2]}, 32'h56);
      check("rd_b3", {24'h0, txq[3]}, 32'h78);
    end

    // Unknown command
    clear_counts();
    send_byte(8'h41);
    wait_idle(100);
    check("nak_tx_count", txq.size(), 1);
    if (txq.size() >= 1) check("nak_byte", {24'h0, txq[0]}, 32'h3F);
    check("nak_rdwr", rd_cnt + wr_cnt, 0);

    // Timeout after two bytes; negedge k follows edge N+k-1 (N = last byte edge)
    clear_counts();
    idle_edge = -1;
    send_byte(8'h57);
    send_byte(8'h40);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!busy && idle_edge < 0) idle_edge = k - 1;
    end
    check("tmo_edge",     idle_edge,  16);
    check("tmo_wr_count", wr_cnt,     0);
    check("tmo_tx_count", txq.size(), 0);
    rdata = 32'h0BADF00D;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    @(negedge clk);
    check("tmo_rd_after", {31'h0, rd}, 32'h1);
    check("tmo_rd_addr",  addr,        32'h00000004);
    wait_idle(200);
    check("tmo_rd_tx_count", txq.size(), 4);
    if (txq.size() == 4) check("tmo_rd_b0", {24'h0, txq[0]}, 32'h0B);

    // Dropped bytes and backpressure during a 4-byte response
    clear_counts();
    hold  = 50;
    rdata = 32'hCAFEBABE;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    @(negedge clk);
    check("bp_rd", {31'h0, rd}, 32'h1);
    send_byte(8'h57);
    send_byte(8'h52);
    send_byte(8'h41);
    wait_idle(600);
    hold = 3;
    check("bp_tx_count", txq.size(), 4);
    if (txq.size() == 4) begin
      check("bp_b0", {24'h0, txq[0]}, 32'hCA);
      check("bp_b1", {24'h0, txq[1]}, 32'hFE);
      check("bp_b2", {24'h0, txq[2]}, 32'hBA);
      check("bp_b3", {24'h0, txq[3]}, 32'hBE);
    end
    repeat (5) @(negedge clk);
    check("bp_still_idle", {31'h0, busy}, 32'h0);
    check("bp_rd_count",   rd_cnt,        1);
    check("bp_wr_count",   wr_cnt,        0);

    // Reset mid-packet after three address bytes
    clear_counts();
    send_byte(8'h57);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_addr",  addr,          32'h0);
    check("mrst_wdata", wdata,         32'h0);
    check("mrst_busy",  {31'h0, busy}, 32'h0);
    check("mrst_strb",  {29'h0, rd, wr, tx_start}, 32'h0);
    reset = 1'b0;
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
    @(negedge clk);
    check("mrst_wr",       {31'h0, wr}, 32'h1);
    check("mrst_wr_addr",  addr,        32'h40000020);
    check("mrst_wr_wdata", wdata,       32'h0000005A);
    wait_idle(100);
    check("mrst_wr_count", wr_cnt,     1);
    check("mrst_tx_count", txq.size(), 1);
    if (txq.size() >= 1) check("mrst_ack", {24'h0, txq[0]}, 32'h4B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
